// File: rtl/dec_pkg.sv
// Shared decoder types and helpers.
//   cw_width_t      : comparator codeword width encoding (8/16/32 bits)
//   asm_state_t     : codeword assembler FSM states
//   norm_width      : folds the raw 2-bit width input onto cw_width_t (1x -> CW_32)
//   beats_for_width : number of input bytes per codeword for a given width
package dec_pkg;

  localparam int unsigned ASM_WORD_BITS = 32;
  localparam int unsigned ASM_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    CW_8  = 2'b00,
    CW_16 = 2'b01,
    CW_32 = 2'b10
  } cw_width_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } asm_state_t;

  // 2'b11 has no enum member; it means 32-bit just like 2'b10.
  function automatic cw_width_t norm_width(input logic [1:0] raw);
    return raw[1] ? CW_32 : cw_width_t'(raw);
  endfunction

  function automatic logic [2:0] beats_for_width(input cw_width_t w);
    case (w)
      CW_8:    return 3'd1;
      CW_16:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dec_codeword_assembler_if.sv
// Byte-in / word-out handshake bundle of the codeword assembler.
//   in_data/in_valid/in_ready : received codeword byte stream
//   codeword_width            : 00=8b, 01=16b, 1x=32b, sampled on first byte of a word
//   abort                     : discard a partial word
//   out_A/out_width           : assembled word and its width, to the comparator
//   out_valid/out_ready       : output word handshake
// slave = assembler side, master = feeder/consumer side.
interface dec_codeword_assembler_if;
  import dec_pkg::*;

  logic [ASM_BYTE_BITS-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               codeword_width;
  logic                     abort;
  logic [ASM_WORD_BITS-1:0] out_A;
  logic [1:0]               out_width;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, codeword_width, abort, out_ready,
    input  in_ready, out_A, out_width, out_valid
  );

  modport slave (
    input  in_data, in_valid, codeword_width, abort, out_ready,
    output in_ready, out_A, out_width, out_valid
  );

endinterface

// File: rtl/dec_codeword_assembler.sv
// Codeword assembler: collects 1/2/4 little-endian bytes into a 32-bit word,
// zero-extended above the active width, and holds it with its width on a
// registered valid/ready output feeding the width-selectable comparator.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dec_codeword_assembler_if.slave (byte input, abort, word output)
module dec_codeword_assembler
  import dec_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  dec_codeword_assembler_if.slave   bus
);

  asm_state_t            state, state_d;
  logic [1:0]            cnt, cnt_d;
  logic [DATA_DEPTH-1:0] sr, sr_d;
  cw_width_t             wl, wl_d;
  logic [DATA_DEPTH-1:0] oa, oa_d;
  cw_width_t             ow, ow_d;

  logic                  in_ready_c;
  logic                  accept;
  cw_width_t             first_w;
  logic [DATA_DEPTH-1:0] byte_zx;
  logic [DATA_DEPTH-1:0] placed;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      wl    <= CW_8;
      oa    <= '0;
      ow    <= CW_8;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sr    <= sr_d;
      wl    <= wl_d;
      oa    <= oa_d;
      ow    <= ow_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    sr_d       = sr;
    wl_d       = wl;
    oa_d       = oa;
    ow_d       = ow;
    in_ready_c = 1'b0;

    // In HOLD the next word's first byte is taken only alongside consumption.
    case (state)
      IDLE, COLLECT: in_ready_c = !bus.abort;
      HOLD:          in_ready_c = bus.out_ready;
      default:       in_ready_c = 1'b0;
    endcase
    if (rst) in_ready_c = 1'b0;

    accept  = bus.in_valid && in_ready_c;
    first_w = norm_width(bus.codeword_width);
    byte_zx = DATA_DEPTH'(bus.in_data);
    placed  = byte_zx << {cnt, 3'b000};

    case (state)
      // IDLE and a consumed HOLD share first-byte handling; abort only
      // applies in IDLE since a completed word is never dropped.
      IDLE, HOLD: begin
        if (state == HOLD && bus.out_ready) state_d = IDLE;
        if (state == IDLE && bus.abort) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (beats_for_width(first_w) == 3'd1) begin
            oa_d    = byte_zx;
            ow_d    = first_w;
            state_d = HOLD;
          end else begin
            sr_d    = byte_zx;
            wl_d    = first_w;
            cnt_d   = 2'd1;
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (bus.abort) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          if ({1'b0, cnt} + 3'd1 == beats_for_width(wl)) begin
            oa_d    = sr | placed;
            ow_d    = wl;
            sr_d    = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            sr_d  = sr | placed;
            cnt_d = cnt + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_A     = oa;
  assign bus.out_width = ow;

endmodule

// File: tb/tb_dec_codeword_assembler.sv
module tb_dec_codeword_assembler;
  import dec_pkg::*;

  logic clk = 1'b0;
  logic rst;

  dec_codeword_assembler_if bus();

  dec_codeword_assembler #(.DATA_DEPTH(32), .BYTE_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Transaction-level reference: a pending completed word (if any) and the
  // list of bytes collected so far for the word under construction.
  bit          m_hold = 1'b0;
  logic [31:0] m_A    = '0;
  logic [1:0]  m_w    = '0;
  logic [7:0]  m_bytes[$];
  int unsigned m_need = 0;
  logic [1:0]  m_pw   = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Applies one cycle of inputs, checks outputs against the reference,
  // advances the reference across the clock edge, then waits for the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [1:0] w,
                       input logic ab, input logic ordy, input logic r);
    logic        exp_ir;
    logic [31:0] word;
    bus.in_valid       = v;
    bus.in_data        = d;
    bus.codeword_width = w;
    bus.abort          = ab;
    bus.out_ready      = ordy;
    rst                = r;
    #1;
    exp_ir = r ? 1'b0 : (m_hold ? ordy : !ab);
    chk("in_ready",  32'(bus.in_ready),  32'(exp_ir));
    chk("out_valid", 32'(bus.out_valid), 32'(m_hold));
    if (m_hold) begin
      chk("out_A",     bus.out_A,           m_A);
      chk("out_width", 32'(bus.out_width),  32'(m_w));
    end
    if (r) begin
      m_hold = 1'b0;
      m_bytes.delete();
    end else begin
      if (m_hold && ordy) m_hold = 1'b0;
      if (v && exp_ir) begin
        if (m_bytes.size() == 0) begin
          m_need = w[1] ? 4 : (w[0] ? 2 : 1);
          m_pw   = w[1] ? 2'b10 : w;
        end
        m_bytes.push_back(d);
        if (m_bytes.size() == m_need) begin
          word = '0;
          for (int k = 0; k < m_bytes.size(); k++)
            word = word + (32'(m_bytes[k]) << (8 * k));
          m_A    = word;
          m_w    = m_pw;
          m_hold = 1'b1;
          m_bytes.delete();
        end
      end else if (ab && !r && !(exp_ir === 1'b1 && m_hold)) begin
        if (!(m_hold && !ordy)) m_bytes.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_data        = '0;
    bus.codeword_width = '0;
    bus.abort          = 1'b0;
    bus.out_ready      = 1'b0;
    rst                = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_A",     bus.out_A,          32'h0);
    chk("rst_out_width", 32'(bus.out_width), 32'h0);

    // 1: 16-bit word
    cycle(1, 8'h34, 2'b01, 0, 0, 0);
    cycle(1, 8'h12, 2'b01, 0, 0, 0);
    chk("t1_valid", 32'(bus.out_valid), 32'h1);
    chk("t1_A",     bus.out_A,          32'h0000_1234);
    chk("t1_width", 32'(bus.out_width), 32'h1);
    cycle(0, 8'h00, 2'b01, 0, 1, 0);

    // 2: 32-bit word held under backpressure
    cycle(1, 8'hEF, 2'b10, 0, 0, 0);
    cycle(1, 8'hBE, 2'b10, 0, 0, 0);
    cycle(1, 8'hAD, 2'b10, 0, 0, 0);
    cycle(1, 8'hDE, 2'b10, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t2_A", bus.out_A, 32'hDEAD_BEEF);
      cycle(1, 8'h99, 2'b00, 0, 0, 0);
    end
    cycle(0, 8'h00, 2'b00, 0, 1, 0);
    chk("t2_drop", 32'(bus.out_valid), 32'h0);

    // 3: back-to-back 8-bit words
    cycle(1, 8'hA5, 2'b00, 0, 1, 0);
    chk("t3_A0", bus.out_A, 32'h0000_00A5);
    cycle(1, 8'h5A, 2'b00, 0, 1, 0);
    chk("t3_A1", bus.out_A, 32'h0000_005A);
    cycle(1, 8'hFF, 2'b00, 0, 1, 0);
    chk("t3_A2", bus.out_A, 32'h0000_00FF);
    chk("t3_valid", 32'(bus.out_valid), 32'h1);
    cycle(0, 8'h00, 2'b00, 0, 1, 0);

    // 4: width change after first byte ignored
    cycle(1, 8'h11, 2'b11, 0, 0, 0);
    cycle(1, 8'h22, 2'b00, 0, 0, 0);
    cycle(1, 8'h33, 2'b00, 0, 0, 0);
    cycle(1, 8'h44, 2'b00, 0, 0, 0);
    chk("t4_A",     bus.out_A,          32'h4433_2211);
    chk("t4_width", 32'(bus.out_width), 32'h2);
    cycle(0, 8'h00, 2'b00, 1, 1, 0);

    // 5: abort mid-word, then fresh 16-bit word
    cycle(1, 8'hC1, 2'b10, 0, 0, 0);
    cycle(1, 8'hC2, 2'b10, 0, 0, 0);
    cycle(1, 8'hC3, 2'b10, 1, 0, 0);
    cycle(1, 8'h78, 2'b01, 0, 0, 0);
    cycle(1, 8'h56, 2'b01, 0, 0, 0);
    chk("t5_A", bus.out_A, 32'h0000_5678);

    // 6: reset while holding, then while collecting
    cycle(0, 8'h00, 2'b00, 0, 0, 1);
    chk("t6_hold_valid", 32'(bus.out_valid), 32'h0);
    chk("t6_hold_A",     bus.out_A,          32'h0);
    cycle(0, 8'h00, 2'b00, 0, 0, 0);
    cycle(1, 8'h01, 2'b10, 0, 0, 0);
    cycle(1, 8'h02, 2'b10, 0, 0, 1);
    chk("t6_col_valid", 32'(bus.out_valid), 32'h0);
    cycle(1, 8'h03, 2'b01, 0, 0, 0);
    cycle(1, 8'h04, 2'b01, 0, 0, 0);
    chk("t6_after_A", bus.out_A, 32'h0000_0403);
    cycle(0, 8'h00, 2'b00, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
            $urandom_range(0, 11) == 0, 1'($urandom), $urandom_range(0, 99) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
